aes_ctr_sched: RTL and testbench
================================

# aes_ctr_sched

Keystream scheduler that shares one `aes_core` instance between the TX and RX channels of the serial security wrapper in AES-CTR mode. It holds a nonce/counter per channel and arbitrates the core round-robin. For each grant it drives `start` with counter block `{nonce, ctr}`, captures the ciphertext as 128 bits of keystream, and presents that keystream to the channel through a one-entry valid/ready buffer. The UART TX/RX datapaths XOR this keystream with their data.

## Interface
- `CTR_W`, default 32: counter width. Nonce width is 128-CTR_W.
- `WAIT_MAX`, default 64: watchdog limit, in cycles, on `aes_done` (only with `AES_SCHED_WDOG_EN`).

Ports (x = tx, rx; each port exists once per channel):
- `clk`  in  1  single clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `key`  in  128  session key, sampled at issue.
- `x_en`  in  1  channel enabled for keystream prefetch.
- `x_clr`  in  1  pulse: load counter from `x_ctr_init`, flush buffer, clear exhausted.
- `x_nonce`  in  128-CTR_W  channel nonce.
- `x_ctr_init`  in  CTR_W  counter start value.
- `x_ks`  out  128  keystream block.
- `x_ks_valid`  out  1  `x_ks` holds an unconsumed block.
- `x_ks_ready`  in  1  consumer accepts `x_ks`.
- `x_exhausted`  out  1  sticky: counter wrapped, channel halted.
- `aes_start`  out  1  one-cycle start pulse to the core.
- `aes_key`  out  128  key to the core.
- `aes_pt`  out  128  counter block to the core.
- `aes_ct`  in  128  core ciphertext.
- `aes_done`  in  1  core completion.
- `busy`  out  1  state ≠ IDLE.
- `err`  out  1  sticky watchdog error.

## Operation
- Eligibility: a channel is eligible when `x_en`=1, `x_exhausted`=0, `x_ks_valid`=0, and the channel is not in flight.
- Arbitration: round-robin on a last-grant pointer. The pointer resets to RX, so TX wins the first tie. A single eligible channel is granted immediately.
- FSM states:
  - IDLE: on any eligible channel, go to ISSUE. Register `aes_pt` = `{x_nonce, x_ctr}` and `aes_key` = `key`.
  - ISSUE: `aes_start`=1 for exactly one cycle, then go to WAIT.
  - WAIT: on the first cycle with `aes_done`=1, capture `aes_ct` into `x_ks`, set `x_ks_valid`, and go to IDLE. `aes_done` is ignored outside WAIT.
- Counter update: the counter increments, modulo 2^CTR_W, when the ciphertext is captured. If the captured block used ctr = all-ones, set `x_exhausted`; the channel is never granted again until `x_clr`, so keystream is never reused.
- Buffer: `x_ks_valid` clears on the `x_ks_valid & x_ks_ready` cycle. `x_ks` holds its value until it is overwritten.
- `x_clr` while that channel is in flight: the in-flight result is discarded (no capture, no increment). The counter is reloaded, and the FSM still returns to IDLE on `aes_done`.
- `x_en` deasserted while in flight: the operation completes and the result is buffered.
- `x_clr` and `x_ks_ready` in the same cycle: `x_clr` wins and the buffer is empty.

## Timing
- Reset (async): `aes_start`, `aes_key`, `aes_pt`, `x_ks`, `x_ks_valid`, `x_exhausted`, `busy`, and `err` are all 0. Counters = 0. FSM = IDLE.
- Eligible in cycle N → `aes_pt` valid and `aes_start`=1 in N+1 → WAIT from N+2.
- `aes_done` in cycle M → `x_ks_valid`=1 from M+1 → next grant evaluated in M+1, so the earliest next `aes_start` is M+2.
- Pop in cycle P → that channel becomes eligible again in P+1.
- `aes_pt` and `aes_key` stay stable from ISSUE through WAIT.
- Reset deassertion mid-operation: the FSM restarts in IDLE and any core result arriving afterwards is ignored.

## Configuration
- `AES_SCHED_WDOG_EN` defined: a WAIT cycle counter runs. If `aes_done` has not arrived after `WAIT_MAX` cycles in WAIT, the FSM goes to IDLE and `err` is set (sticky until reset). There is no capture and no increment, and the same counter block is retried on the next grant.
- Not defined: WAIT lasts indefinitely and `err` is tied to 0.

## Structure
- Package `aes_sched_pkg` holds:
  - the state enum (IDLE, ISSUE, WAIT);
  - channel index constants `CH_TX`=0 and `CH_RX`=1;
  - `BLK_W`=128.
- Sub-module `aes_ks_chan`, instantiated twice, contains the per-channel counter, the keystream buffer, the valid/ready handshake, exhausted flag and clr handling. The FSM, arbiter and watchdog live in the top level.

## Test plan
- Reset with `key`=000102030405060708090A0B0C0D0E0F, TX nonce 00112233445566778899AABB, `tx_ctr_init`=CCDDEEFF, `tx_clr` pulse, `tx_en`=1 with a real `aes_core`: `aes_pt`=00112233445566778899AABBCCDDEEFF and `aes_start` is one cycle. Then `tx_ks`=69c4e0d86a7b0430d8cdb78070b4c55a with `tx_ks_valid`=1. After the pop, the next `aes_pt` ends in CCDDEF00.
- Both channels enabled with `ks_ready` held at 1: grants alternate TX, RX, TX, RX. Each channel's counter increments by 1 per block.
- `CTR_W`=32 with `rx_ctr_init`=FFFFFFFF: exactly one block is produced, then `rx_exhausted`=1 and there are no further RX starts. `rx_clr` restores service.
- `tx_ks_ready` held at 0: exactly one TX block is issued and the core serves RX only. Raising ready for one cycle produces a TX start within 2 cycles.
- `tx_clr` during WAIT: `tx_ks_valid` stays 0 and the next TX `aes_pt` uses `tx_ctr_init`.
- With `AES_SCHED_WDOG_EN` and `aes_done` stuck at 0: `err`=1 after `WAIT_MAX` cycles and the same `aes_pt` is reissued. With the macro undefined, `busy` stays 1 and `err` stays 0.

Source files
------------

// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES-CTR keystream scheduler.
package aes_sched_pkg;
  localparam int   BLK_W = 128;
  localparam logic CH_TX = 1'b0;
  localparam logic CH_RX = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
endpackage

// File: rtl/aes_ks_chan.sv
// One keystream channel: nonce/counter, one-entry keystream buffer with
// valid/ready handshake, sticky exhaustion flag and clear handling.
module aes_ks_chan
  import aes_sched_pkg::*;
#(
  parameter int CTR_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   clr,
  input  logic [BLK_W-CTR_W-1:0] nonce,
  input  logic [CTR_W-1:0]       ctr_init,
  input  logic                   inflight,
  input  logic                   capture,
  input  logic [BLK_W-1:0]       ct,
  input  logic                   ks_ready,
  output logic [BLK_W-1:0]       ks,
  output logic                   ks_valid,
  output logic                   exhausted,
  output logic                   eligible,
  output logic [BLK_W-1:0]       blk
);
  logic [CTR_W-1:0] ctr;
  logic             kill;
  logic             take;

  // A clear during flight poisons the outstanding result until the core returns.
  assign take     = capture & ~kill & ~clr;
  assign eligible = en & ~exhausted & ~ks_valid & ~inflight & ~clr;
  assign blk      = {nonce, ctr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctr       <= '0;
      ks        <= '0;
      ks_valid  <= 1'b0;
      exhausted <= 1'b0;
      kill      <= 1'b0;
    end else begin
      if (clr) begin
        ctr       <= ctr_init;
        ks_valid  <= 1'b0;
        exhausted <= 1'b0;
      end else if (take) begin
        ctr      <= ctr + CTR_W'(1);
        ks_valid <= 1'b1;
        if (&ctr) exhausted <= 1'b1;
      end else if (ks_valid & ks_ready) begin
        ks_valid <= 1'b0;
      end

      if (take) ks <= ct;

      if (clr & inflight) kill <= 1'b1;
      else if (!inflight) kill <= 1'b0;
    end
  end
endmodule

// File: rtl/aes_ctr_sched.sv
// Shares one AES core between TX and RX CTR-mode keystream channels.
// Optional watchdog on aes_done: define AES_SCHED_WDOG_EN.
module aes_ctr_sched
  import aes_sched_pkg::*;
#(
  parameter int CTR_W    = 32,
  parameter int WAIT_MAX = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [BLK_W-1:0]       key,
  input  logic                   tx_en,
  input  logic                   tx_clr,
  input  logic [BLK_W-CTR_W-1:0] tx_nonce,
  input  logic [CTR_W-1:0]       tx_ctr_init,
  output logic [BLK_W-1:0]       tx_ks,
  output logic                   tx_ks_valid,
  input  logic                   tx_ks_ready,
  output logic                   tx_exhausted,
  input  logic                   rx_en,
  input  logic                   rx_clr,
  input  logic [BLK_W-CTR_W-1:0] rx_nonce,
  input  logic [CTR_W-1:0]       rx_ctr_init,
  output logic [BLK_W-1:0]       rx_ks,
  output logic                   rx_ks_valid,
  input  logic                   rx_ks_ready,
  output logic                   rx_exhausted,
  output logic                   aes_start,
  output logic [BLK_W-1:0]       aes_key,
  output logic [BLK_W-1:0]       aes_pt,
  input  logic [BLK_W-1:0]       aes_ct,
  input  logic                   aes_done,
  output logic                   busy,
  output logic                   err
);
  state_t           state;
  logic             gnt;
  logic             last;
  logic             pick;
  logic             elig_tx, elig_rx;
  logic [BLK_W-1:0] blk_tx, blk_rx;
  logic             in_wait;

  assign busy    = (state != IDLE);
  assign in_wait = (state == WAIT);

  aes_ks_chan #(.CTR_W(CTR_W)) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (tx_en),
    .clr      (tx_clr),
    .nonce    (tx_nonce),
    .ctr_init (tx_ctr_init),
    .inflight (busy & (gnt == CH_TX)),
    .capture  (in_wait & aes_done & (gnt == CH_TX)),
    .ct       (aes_ct),
    .ks_ready (tx_ks_ready),
    .ks       (tx_ks),
    .ks_valid (tx_ks_valid),
    .exhausted(tx_exhausted),
    .eligible (elig_tx),
    .blk      (blk_tx)
  );

  aes_ks_chan #(.CTR_W(CTR_W)) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (rx_en),
    .clr      (rx_clr),
    .nonce    (rx_nonce),
    .ctr_init (rx_ctr_init),
    .inflight (busy & (gnt == CH_RX)),
    .capture  (in_wait & aes_done & (gnt == CH_RX)),
    .ct       (aes_ct),
    .ks_ready (rx_ks_ready),
    .ks       (rx_ks),
    .ks_valid (rx_ks_valid),
    .exhausted(rx_exhausted),
    .eligible (elig_rx),
    .blk      (blk_rx)
  );

  // Round-robin: on a tie the channel that did not win last time goes first.
  always_comb begin
    if (elig_tx & elig_rx) pick = ~last;
    else                   pick = elig_rx ? CH_RX : CH_TX;
  end

`ifdef AES_SCHED_WDOG_EN
  localparam int WCNT_W = $clog2(WAIT_MAX + 1);
  logic [WCNT_W-1:0] wcnt;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= CH_TX;
      last      <= CH_RX;
      aes_start <= 1'b0;
      aes_key   <= '0;
      aes_pt    <= '0;
`ifdef AES_SCHED_WDOG_EN
      wcnt      <= '0;
      err       <= 1'b0;
`endif
    end else begin
      aes_start <= 1'b0;
      case (state)
        IDLE: begin
          if (elig_tx | elig_rx) begin
            state     <= ISSUE;
            gnt       <= pick;
            last      <= pick;
            aes_pt    <= (pick == CH_RX) ? blk_rx : blk_tx;
            aes_key   <= key;
            aes_start <= 1'b1;
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef AES_SCHED_WDOG_EN
          wcnt  <= '0;
`endif
        end
        WAIT: begin
          if (aes_done) begin
            state <= IDLE;
          end
`ifdef AES_SCHED_WDOG_EN
          else if (wcnt == WCNT_W'(WAIT_MAX - 1)) begin
            state <= IDLE;
            err   <= 1'b1;
          end else begin
            wcnt <= wcnt + WCNT_W'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_ctr_sched.sv
// Self-checking bench for aes_ctr_sched with a behavioural AES core stand-in.
module tb_aes_ctr_sched;
  localparam int CTR_W    = 32;
  localparam int WAIT_MAX = 8;
  localparam logic [127:0] KEY0 = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [95:0]  TXN  = 96'h00112233445566778899AABB;
  localparam logic [95:0]  RXN  = 96'hF0E1D2C3B4A5968778695A4B;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] FIPS_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [127:0] key;
  logic tx_en, tx_clr, tx_ks_ready, rx_en, rx_clr, rx_ks_ready;
  logic [95:0] tx_nonce, rx_nonce;
  logic [CTR_W-1:0] tx_ctr_init, rx_ctr_init;
  logic [127:0] tx_ks, rx_ks, aes_key, aes_pt;
  logic tx_ks_valid, tx_exhausted, rx_ks_valid, rx_exhausted;
  logic aes_start, busy, err;
  logic [127:0] aes_ct = '0;
  logic aes_done = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [127:0] q_tx[$];
  logic [127:0] q_rx[$];

  int   core_lat = 2;
  logic core_stuck = 1'b0;
  logic c_busy = 1'b0;
  int   c_cnt = 0;
  logic [127:0] c_res = '0;

  always #5 clk = ~clk;

  aes_ctr_sched #(.CTR_W(CTR_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .key(key),
    .tx_en(tx_en), .tx_clr(tx_clr), .tx_nonce(tx_nonce), .tx_ctr_init(tx_ctr_init),
    .tx_ks(tx_ks), .tx_ks_valid(tx_ks_valid), .tx_ks_ready(tx_ks_ready), .tx_exhausted(tx_exhausted),
    .rx_en(rx_en), .rx_clr(rx_clr), .rx_nonce(rx_nonce), .rx_ctr_init(rx_ctr_init),
    .rx_ks(rx_ks), .rx_ks_valid(rx_ks_valid), .rx_ks_ready(rx_ks_ready), .rx_exhausted(rx_exhausted),
    .aes_start(aes_start), .aes_key(aes_key), .aes_pt(aes_pt), .aes_ct(aes_ct),
    .aes_done(aes_done), .busy(busy), .err(err)
  );

  // Core stand-in: the FIPS-197 known answer for the reference block, a cheap mix otherwise.
  function automatic logic [127:0] core_f(input logic [127:0] k, input logic [127:0] p);
    if (k == KEY0 && p == FIPS_PT) return FIPS_CT;
    return p ^ {k[63:0], k[127:64]} ^ 128'hA5A55A5A3C3CC3C30F0FF0F096696996;
  endfunction

  always @(posedge clk) begin
    aes_done <= 1'b0;
    if (aes_start) begin
      c_busy <= 1'b1;
      c_cnt  <= core_lat;
      c_res  <= core_f(aes_key, aes_pt);
    end else if (c_busy && !core_stuck) begin
      if (c_cnt <= 1) begin
        aes_done <= 1'b1;
        aes_ct   <= c_res;
        c_busy   <= 1'b0;
      end else begin
        c_cnt <= c_cnt - 1;
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Scoreboard: every consumed block must match the oldest expected block.
  always begin
    @(negedge clk);
    #2;
    if (rst_n === 1'b1 && tx_ks_valid === 1'b1 && tx_ks_ready === 1'b1) begin
      if (q_tx.size() == 0) chk("tx_ks unexpected block", tx_ks, 'x);
      else chk("tx_ks scoreboard", tx_ks, q_tx.pop_front());
    end
    if (rst_n === 1'b1 && rx_ks_valid === 1'b1 && rx_ks_ready === 1'b1) begin
      if (q_rx.size() == 0) chk("rx_ks unexpected block", rx_ks, 'x);
      else chk("rx_ks scoreboard", rx_ks, q_rx.pop_front());
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_start(input string nm, input int budget);
    int n = 0;
    while (aes_start !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " aes_start seen"}, aes_start, 1'b1);
  endtask

  task automatic wait_drain(input string nm, input int budget);
    int n = 0;
    while ((q_tx.size() != 0 || q_rx.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " blocks outstanding"}, q_tx.size() + q_rx.size(), 0);
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " busy"}, busy, 1'b0);
  endtask

  typedef struct {
    logic [31:0]  init;
    logic [127:0] pt;
    logic [127:0] ks;
  } vec_t;
  vec_t vt[4];

  initial begin
    int n_st;
    int tx_n;
    logic [31:0] rx_exp;

    vt[0] = '{32'hCCDDEEFF, FIPS_PT, FIPS_CT};
    vt[1] = '{32'h00000000, 128'h00112233445566778899AABB00000000, '0};
    vt[2] = '{32'h7FFFFFFF, 128'h00112233445566778899AABB7FFFFFFF, '0};
    vt[3] = '{32'h12345678, 128'h00112233445566778899AABB12345678, '0};
    for (int i = 1; i < 4; i++) vt[i].ks = core_f(KEY0, vt[i].pt);

    key = KEY0;
    tx_en = 0; tx_clr = 0; tx_nonce = TXN; tx_ctr_init = '0; tx_ks_ready = 0;
    rx_en = 0; rx_clr = 0; rx_nonce = RXN; rx_ctr_init = '0; rx_ks_ready = 0;
    cyc(2);
    chk("rst aes_start", aes_start, 0);
    chk("rst aes_key", aes_key, 0);
    chk("rst aes_pt", aes_pt, 0);
    chk("rst tx_ks", tx_ks, 0);
    chk("rst tx_ks_valid", tx_ks_valid, 0);
    chk("rst tx_exhausted", tx_exhausted, 0);
    chk("rst rx_ks", rx_ks, 0);
    chk("rst rx_ks_valid", rx_ks_valid, 0);
    chk("rst rx_exhausted", rx_exhausted, 0);
    chk("rst busy", busy, 0);
    chk("rst err", err, 0);
    rst_n = 1;
    cyc(1);

    // Alternation from reset: counters start at 0, TX wins the first tie.
    core_lat = 3;
    tx_ks_ready = 1; rx_ks_ready = 1;
    q_tx.push_back(core_f(KEY0, {TXN, 32'h0}));
    q_tx.push_back(core_f(KEY0, {TXN, 32'h1}));
    q_rx.push_back(core_f(KEY0, {RXN, 32'h0}));
    q_rx.push_back(core_f(KEY0, {RXN, 32'h1}));
    tx_en = 1; rx_en = 1;
    cyc(1);
    chk("alt first start latency", aes_start, 1);
    chk("alt first grant tx", aes_pt, {TXN, 32'h0});
    chk("alt key", aes_key, KEY0);
    for (int k = 1; k < 4; k++) begin
      cyc(1);
      wait_start("alt", 20);
      chk($sformatf("alt grant %0d", k), aes_pt,
          (k % 2 == 1) ? {RXN, 32'(k / 2)} : {TXN, 32'(k / 2)});
    end
    tx_en = 0; rx_en = 0;
    wait_drain("alt", 40);

    // Reference block: FIPS-197 answer, buffer held while ready is low.
    tx_ks_ready = 0;
    tx_clr = 1; tx_ctr_init = 32'hCCDDEEFF;
    cyc(1);
    tx_clr = 0; tx_en = 1;
    q_tx.push_back(FIPS_CT);
    cyc(1);
    chk("fips start latency", aes_start, 1);
    chk("fips aes_pt", aes_pt, FIPS_PT);
    tx_en = 0;
    cyc(1);
    chk("fips start one cycle", aes_start, 0);
    chk("fips pt stable", aes_pt, FIPS_PT);
    chk("fips busy", busy, 1);
    n_st = 0;
    while (tx_ks_valid !== 1'b1 && n_st < 20) begin cyc(1); n_st++; end
    chk("fips tx_ks_valid", tx_ks_valid, 1);
    chk("fips tx_ks", tx_ks, FIPS_CT);
    tx_ks_ready = 1;
    wait_drain("fips", 10);
    q_tx.push_back(core_f(KEY0, {TXN, 32'hCCDDEF00}));
    tx_en = 1;
    wait_start("fips next", 10);
    chk("fips next aes_pt", aes_pt, {TXN, 32'hCCDDEF00});
    tx_en = 0;
    wait_drain("fips next", 20);

    for (int i = 0; i < 4; i++) begin
      tx_clr = 1; tx_ctr_init = vt[i].init;
      cyc(1);
      tx_clr = 0;
      q_tx.push_back(vt[i].ks);
      tx_en = 1;
      wait_start("vec", 10);
      chk($sformatf("vec%0d aes_pt", i), aes_pt, vt[i].pt);
      tx_en = 0;
      wait_drain("vec", 30);
    end

    // Counter at all-ones: one block, then halted until cleared.
    rx_clr = 1; rx_ctr_init = 32'hFFFFFFFF;
    cyc(1);
    rx_clr = 0;
    q_rx.push_back(core_f(KEY0, {RXN, 32'hFFFFFFFF}));
    rx_en = 1;
    wait_start("exh", 10);
    chk("exh aes_pt", aes_pt, {RXN, 32'hFFFFFFFF});
    wait_drain("exh", 30);
    cyc(2);
    chk("exh rx_exhausted set", rx_exhausted, 1);
    n_st = 0;
    repeat (20) begin cyc(1); if (aes_start === 1'b1) n_st++; end
    chk("exh no further starts", n_st, 0);
    q_rx.push_back(core_f(KEY0, {RXN, 32'h5}));
    rx_clr = 1; rx_ctr_init = 32'h5;
    cyc(1);
    rx_clr = 0;
    chk("exh cleared by rx_clr", rx_exhausted, 0);
    wait_start("exh restore", 10);
    chk("exh restore aes_pt", aes_pt, {RXN, 32'h5});
    rx_en = 0;
    wait_drain("exh restore", 30);

    // TX stalled by ready=0: core serves RX only.
    tx_clr = 1; tx_ctr_init = 32'h40;
    rx_clr = 1; rx_ctr_init = 32'h80;
    cyc(1);
    tx_clr = 0; rx_clr = 0;
    tx_ks_ready = 0; rx_ks_ready = 1;
    q_tx.push_back(core_f(KEY0, {TXN, 32'h40}));
    tx_en = 1; rx_en = 1;
    tx_n = 0; rx_exp = 32'h80;
    repeat (60) begin
      cyc(1);
      if (aes_start === 1'b1) begin
        if (aes_pt[127:32] == TXN) tx_n++;
        else begin
          chk("stall rx aes_pt", aes_pt, {RXN, rx_exp});
          q_rx.push_back(core_f(KEY0, {RXN, rx_exp}));
          rx_exp = rx_exp + 1;
        end
      end
    end
    rx_en = 0;
    chk("stall one tx block", tx_n, 1);
    chk("stall rx served", (rx_exp - 32'h80) >= 5, 1);
    wait_idle("stall", 20);
    cyc(2);
    chk("stall tx held", tx_ks_valid, 1);
    tx_ks_ready = 1;
    cyc(1);
    tx_ks_ready = 0;
    q_tx.push_back(core_f(KEY0, {TXN, 32'h41}));
    wait_start("ready pulse", 2);
    chk("ready pulse aes_pt", aes_pt, {TXN, 32'h41});
    tx_en = 0;
    tx_ks_ready = 1;
    wait_drain("stall", 30);

    // Clear while in flight discards the result.
    core_lat = 6;
    tx_clr = 1; tx_ctr_init = 32'h300;
    cyc(1);
    tx_clr = 0; tx_en = 1;
    wait_start("clrw", 10);
    chk("clrw aes_pt", aes_pt, {TXN, 32'h300});
    tx_en = 0;
    cyc(1);
    tx_clr = 1; tx_ctr_init = 32'h500;
    cyc(1);
    tx_clr = 0;
    wait_idle("clrw", 20);
    chk("clrw discarded", tx_ks_valid, 0);
    q_tx.push_back(core_f(KEY0, {TXN, 32'h500}));
    tx_en = 1;
    wait_start("clrw reload", 10);
    chk("clrw reload aes_pt", aes_pt, {TXN, 32'h500});
    tx_en = 0;
    wait_drain("clrw", 30);

    // Reset mid-operation: late core result ignored, counters back to 0.
    core_lat = 5;
    tx_en = 1;
    wait_start("rstmid", 10);
    tx_en = 0;
    cyc(2);
    rst_n = 0;
    cyc(1);
    rst_n = 1;
    cyc(10);
    chk("rstmid busy", busy, 0);
    chk("rstmid no capture", tx_ks_valid, 0);
    chk("rstmid aes_pt", aes_pt, 0);
    q_tx.push_back(core_f(KEY0, {TXN, 32'h0}));
    tx_en = 1;
    wait_start("rstmid restart", 10);
    chk("rstmid restart aes_pt", aes_pt, {TXN, 32'h0});
    tx_en = 0;
    wait_drain("rstmid", 30);

`ifdef AES_SCHED_WDOG_EN
    core_stuck = 1;
    tx_clr = 1; tx_ctr_init = 32'h77;
    cyc(1);
    tx_clr = 0; tx_en = 1;
    wait_start("wdog", 10);
    chk("wdog aes_pt", aes_pt, {TXN, 32'h77});
    cyc(WAIT_MAX);
    chk("wdog err before limit", err, 0);
    cyc(1);
    chk("wdog err at limit", err, 1);
    wait_start("wdog retry", 3);
    chk("wdog retry aes_pt", aes_pt, {TXN, 32'h77});
    tx_en = 0;
    wait_idle("wdog", 3 * WAIT_MAX);
    chk("wdog err sticky", err, 1);
    chk("wdog no capture", tx_ks_valid, 0);
`else
    core_stuck = 1;
    tx_en = 1;
    wait_start("hang", 10);
    tx_en = 0;
    cyc(100);
    chk("hang busy", busy, 1);
    chk("hang err", err, 0);
`endif

    chk("final tx queue", q_tx.size(), 0);
    chk("final rx queue", q_rx.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end
endmodule
